// File: rtl/cx4_mmio_pkg.sv
// Cx4 MMIO responder shared definitions: register offsets within the
// $6000-$7FFF window, data-RAM wrap limit, status bit position, FSM states
// and the destination-address wrap helper.
package cx4_mmio_pkg;

  // Register offsets as seen on SNES_ADDR[12:0]
  localparam logic [12:0] OFS_SRC0   = 13'h1F40;
  localparam logic [12:0] OFS_SRC1   = 13'h1F41;
  localparam logic [12:0] OFS_SRC2   = 13'h1F42;
  localparam logic [12:0] OFS_LEN0   = 13'h1F43;
  localparam logic [12:0] OFS_LEN1   = 13'h1F44;
  localparam logic [12:0] OFS_DST0   = 13'h1F45;
  localparam logic [12:0] OFS_DST1   = 13'h1F46;
  localparam logic [12:0] OFS_GO     = 13'h1F47;
  localparam logic [12:0] OFS_STATUS = 13'h1F5E;

  // Last valid Cx4 data-RAM address; the destination wraps to 0 after it
  localparam logic [11:0] RAM_LIMIT = 12'hBFF;

  // Position of the busy flag in the status byte
  localparam logic [2:0] STATUS_BUSY_BIT = 3'd6;

  // Transfer engine states
  typedef enum logic [1:0] {
    CX4_IDLE  = 2'd0,
    CX4_REQ   = 2'd1,
    CX4_WRITE = 2'd2,
    CX4_NEXT  = 2'd3
  } cx4_state_e;

  // Advance a data-RAM address, wrapping at the end of the 3 KiB RAM
  function automatic logic [11:0] next_dst(input logic [11:0] dst);
    if (dst == RAM_LIMIT) begin
      return 12'h000;
    end else begin
      return dst + 12'h001;
    end
  endfunction

endpackage

// File: rtl/cx4_mmio_responder_if.sv
// Bus bundle of the Cx4 MMIO responder: SNES window side, ROM DMA handshake
// and the Cx4 data-RAM write port. The slave modport is the responder view.
interface cx4_mmio_responder_if;

  logic        CX4_EN;
  logic [12:0] SNES_ADDR;
  logic        SNES_RD_N;
  logic        SNES_WR_N;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  logic        SNES_DATA_OE;
  logic        DMA_REQ;
  logic [23:0] DMA_ADDR;
  logic        DMA_ACK;
  logic [7:0]  DMA_DATA;
  logic        RAM_WE;
  logic [11:0] RAM_ADDR;
  logic [7:0]  RAM_DATA;
  logic        BUSY;

  modport master (
    output CX4_EN, SNES_ADDR, SNES_RD_N, SNES_WR_N, SNES_DATA_IN,
    input  SNES_DATA_OUT, SNES_DATA_OE,
    input  DMA_REQ, DMA_ADDR,
    output DMA_ACK, DMA_DATA,
    input  RAM_WE, RAM_ADDR, RAM_DATA, BUSY
  );

  modport slave (
    input  CX4_EN, SNES_ADDR, SNES_RD_N, SNES_WR_N, SNES_DATA_IN,
    output SNES_DATA_OUT, SNES_DATA_OE,
    output DMA_REQ, DMA_ADDR,
    input  DMA_ACK, DMA_DATA,
    output RAM_WE, RAM_ADDR, RAM_DATA, BUSY
  );

endinterface

// File: rtl/cx4_mmio_responder_strobe_sync.sv
// snes_strobe_sync: brings one raw asynchronous SNES strobe (active low)
// into the CLK domain through three flops and flags its rising edge with a
// registered pulse aligned to the first cycle the synchronized level is high.
module snes_strobe_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic strobe_n,
  output logic sync_n,
  output logic rise
);

  logic meta_r;
  logic mid_r;
  logic sync_r;
  logic rise_r;

  // Synchronizer chain idles high (strobe inactive); edge pulse tracks it
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_r <= 1'b1;
      mid_r  <= 1'b1;
      sync_r <= 1'b1;
      rise_r <= 1'b0;
    end else begin
      meta_r <= strobe_n;
      mid_r  <= meta_r;
      sync_r <= mid_r;
      rise_r <= mid_r & ~sync_r;
    end
  end

  assign sync_n = sync_r;
  assign rise   = rise_r;

endmodule

// File: rtl/cx4_mmio_responder.sv
// cx4_mmio_responder: Cx4 MMIO register file plus a byte-wise ROM->data-RAM
// transfer engine. SRC/LEN/DST are programmed through $7F40-$7F46, a write
// to $7F47 starts the copy, $7F5E reports BUSY in bit 6.
// Optional build macro: CX4_MMIO_READBACK_EN makes $7F40-$7F47 readable.
module cx4_mmio_responder
  import cx4_mmio_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  cx4_mmio_responder_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = CX4_IDLE;
  localparam logic [1:0] ST_REQ   = CX4_REQ;
  localparam logic [1:0] ST_WRITE = CX4_WRITE;
  localparam logic [1:0] ST_NEXT  = CX4_NEXT;

  logic        rd_sync_n_s;
  logic        rd_rise_s;
  logic        wr_sync_n_s;
  logic        wr_rise_s;
  logic        unused_s;
  logic        commit_s;
  logic        start_s;
  logic [7:0]  wdata_r;
  logic [23:0] src_r;
  logic [15:0] len_r;
  logic [11:0] dst_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [23:0] src_w_r;
  logic [11:0] dst_w_r;
  logic [15:0] cnt_r;
  logic [7:0]  byte_r;
  logic        dma_req_r;
  logic        ram_we_r;
  logic        busy_r;
  logic [7:0]  rdata_r;
  logic [7:0]  rdata_nxt_s;

  snes_strobe_sync u_rd_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .strobe_n (bus.SNES_RD_N),
    .sync_n   (rd_sync_n_s),
    .rise     (rd_rise_s)
  );

  snes_strobe_sync u_wr_sync (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .strobe_n (bus.SNES_WR_N),
    .sync_n   (wr_sync_n_s),
    .rise     (wr_rise_s)
  );

  // Reads complete on the level, so the read-strobe edge pulse has no user
  assign unused_s = rd_rise_s;

  // Register writes only land while idle; a $47 write is the start command
  assign commit_s = wr_rise_s & bus.CX4_EN & (state_r == ST_IDLE);
  assign start_s  = commit_s & (bus.SNES_ADDR == OFS_GO);

  // Hold the last byte seen while the synchronized write strobe was low
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdata_r <= 8'h00;
    end else if (!wr_sync_n_s) begin
      wdata_r <= bus.SNES_DATA_IN;
    end else begin
      wdata_r <= wdata_r;
    end
  end

  // Programmed SRC/LEN/DST registers; the engine never modifies them
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_r <= 24'h000000;
      len_r <= 16'h0000;
      dst_r <= 12'h000;
    end else if (commit_s) begin
      case (bus.SNES_ADDR)
        OFS_SRC0: src_r[7:0]   <= wdata_r;
        OFS_SRC1: src_r[15:8]  <= wdata_r;
        OFS_SRC2: src_r[23:16] <= wdata_r;
        OFS_LEN0: len_r[7:0]   <= wdata_r;
        OFS_LEN1: len_r[15:8]  <= wdata_r;
        OFS_DST0: dst_r[7:0]   <= wdata_r;
        OFS_DST1: dst_r[11:8]  <= wdata_r[3:0];
        default: begin
        end
      endcase
    end else begin
      src_r <= src_r;
    end
  end

  // Next-state decode of the transfer engine
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s && (len_r != 16'h0000)) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.DMA_ACK) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WRITE: state_nxt_s = ST_NEXT;
      ST_NEXT: begin
        if (cnt_r == 16'h0001) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and the outputs decoded from the upcoming state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r   <= ST_IDLE;
      dma_req_r <= 1'b0;
      ram_we_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      dma_req_r <= (state_nxt_s == ST_REQ);
      ram_we_r  <= (state_nxt_s == ST_WRITE);
      busy_r    <= (state_nxt_s != ST_IDLE);
    end
  end

  // Working copies of source/destination/count and the fetched byte
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_w_r <= 24'h000000;
      dst_w_r <= 12'h000;
      cnt_r   <= 16'h0000;
      byte_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (state_nxt_s == ST_REQ) begin
            src_w_r <= src_r;
            dst_w_r <= dst_r;
            cnt_r   <= len_r;
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        ST_REQ: begin
          if (bus.DMA_ACK) begin
            byte_r <= bus.DMA_DATA;
          end else begin
            byte_r <= byte_r;
          end
        end
        ST_NEXT: begin
          src_w_r <= src_w_r + 24'h000001;
          dst_w_r <= next_dst(dst_w_r);
          cnt_r   <= cnt_r - 16'h0001;
        end
        default: begin
        end
      endcase
    end
  end

  // Read-data decode for the current SNES address
  always_comb begin
    rdata_nxt_s = 8'h00;
    case (bus.SNES_ADDR)
      OFS_STATUS: rdata_nxt_s[STATUS_BUSY_BIT] = busy_r;
`ifdef CX4_MMIO_READBACK_EN
      OFS_SRC0:   rdata_nxt_s = src_r[7:0];
      OFS_SRC1:   rdata_nxt_s = src_r[15:8];
      OFS_SRC2:   rdata_nxt_s = src_r[23:16];
      OFS_LEN0:   rdata_nxt_s = len_r[7:0];
      OFS_LEN1:   rdata_nxt_s = len_r[15:8];
      OFS_DST0:   rdata_nxt_s = dst_r[7:0];
      OFS_DST1:   rdata_nxt_s = {4'h0, dst_r[11:8]};
      OFS_GO:     rdata_nxt_s = 8'h00;
`endif
      default:    rdata_nxt_s = 8'h00;
    endcase
  end

  // Registered read data, one cycle behind the address
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_r <= 8'h00;
    end else begin
      rdata_r <= rdata_nxt_s;
    end
  end

  assign bus.SNES_DATA_OUT = rdata_r;
  assign bus.SNES_DATA_OE  = bus.CX4_EN & ~rd_sync_n_s;
  assign bus.DMA_REQ       = dma_req_r;
  assign bus.DMA_ADDR      = src_w_r;
  assign bus.RAM_WE        = ram_we_r;
  assign bus.RAM_ADDR      = dst_w_r;
  assign bus.RAM_DATA      = byte_r;
  assign bus.BUSY          = busy_r;

endmodule

// File: tb/tb_cx4_mmio_responder.sv
// Directed self-checking bench for cx4_mmio_responder. Build with
// CX4_MMIO_READBACK_EN defined to also cover register readback.
module tb_cx4_mmio_responder;

`ifdef CX4_MMIO_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  int   vectors;
  int   miscompares;

  cx4_mmio_responder_if bus ();

  cx4_mmio_responder dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic snes_write(input logic [12:0] addr, input logic [7:0] data);
    bus.CX4_EN       = 1'b1;
    bus.SNES_ADDR    = addr;
    bus.SNES_DATA_IN = data;
    bus.SNES_WR_N    = 1'b0;
    repeat (4) tick();
    bus.SNES_WR_N    = 1'b1;
    repeat (5) tick();
  endtask

  task automatic snes_read(input string tag, input logic [12:0] addr, input logic [7:0] exp);
    bus.CX4_EN    = 1'b1;
    bus.SNES_ADDR = addr;
    bus.SNES_RD_N = 1'b0;
    repeat (4) tick();
    chk({tag, "_oe"}, 32'(bus.SNES_DATA_OE), 32'd1);
    chk(tag, 32'(bus.SNES_DATA_OUT), 32'(exp));
    bus.SNES_RD_N = 1'b1;
    repeat (4) tick();
    chk({tag, "_oe_off"}, 32'(bus.SNES_DATA_OE), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    bit seen;
    seen = (bus.DMA_REQ === 1'b1);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = (bus.DMA_REQ === 1'b1);
    end
    chk({tag, "_req_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic do_byte(input string tag, input logic [23:0] exp_src,
                         input logic [11:0] exp_dst, input logic [7:0] data,
                         input bit last);
    logic [23:0] nxt_src;
    nxt_src = exp_src + 24'h000001;
    wait_req(tag);
    chk({tag, "_dma_addr"}, 32'(bus.DMA_ADDR), 32'(exp_src));
    chk({tag, "_busy"}, 32'(bus.BUSY), 32'd1);
    repeat (2) tick();
    chk({tag, "_req_hold"}, 32'(bus.DMA_REQ), 32'd1);
    chk({tag, "_addr_hold"}, 32'(bus.DMA_ADDR), 32'(exp_src));
    chk({tag, "_no_we"}, 32'(bus.RAM_WE), 32'd0);
    bus.DMA_ACK  = 1'b1;
    bus.DMA_DATA = data;
    tick();
    bus.DMA_ACK  = 1'b0;
    bus.DMA_DATA = 8'h00;
    chk({tag, "_we"}, 32'(bus.RAM_WE), 32'd1);
    chk({tag, "_ram_addr"}, 32'(bus.RAM_ADDR), 32'(exp_dst));
    chk({tag, "_ram_data"}, 32'(bus.RAM_DATA), 32'(data));
    chk({tag, "_req_drop"}, 32'(bus.DMA_REQ), 32'd0);
    tick();
    chk({tag, "_we_1cyc"}, 32'(bus.RAM_WE), 32'd0);
    chk({tag, "_busy_next"}, 32'(bus.BUSY), 32'd1);
    tick();
    if (last) begin
      chk({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
      chk({tag, "_req_end"}, 32'(bus.DMA_REQ), 32'd0);
    end else begin
      chk({tag, "_req_again"}, 32'(bus.DMA_REQ), 32'd1);
      chk({tag, "_src_inc"}, 32'(bus.DMA_ADDR), 32'(nxt_src));
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.DMA_REQ !== 1'b0 || bus.BUSY !== 1'b0 || bus.RAM_WE !== 1'b0) bad = 1'b1;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    RST_N            = 1'b0;
    bus.CX4_EN       = 1'b0;
    bus.SNES_ADDR    = 13'h0000;
    bus.SNES_RD_N    = 1'b1;
    bus.SNES_WR_N    = 1'b1;
    bus.SNES_DATA_IN = 8'h00;
    bus.DMA_ACK      = 1'b0;
    bus.DMA_DATA     = 8'h00;

    // Reset state
    #3;
    chk("rst_dma_req", 32'(bus.DMA_REQ), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_ram_we", 32'(bus.RAM_WE), 32'd0);
    chk("rst_oe", 32'(bus.SNES_DATA_OE), 32'd0);
    chk("rst_dout", 32'(bus.SNES_DATA_OUT), 32'd0);
    chk("rst_dma_addr", 32'(bus.DMA_ADDR), 32'd0);
    chk("rst_ram_addr", 32'(bus.RAM_ADDR), 32'd0);
    chk("rst_ram_data", 32'(bus.RAM_DATA), 32'd0);
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    snes_read("status_idle", 13'h1F5E, 8'h00);
    snes_read("unmapped", 13'h1F50, 8'h00);

    // Basic transfer: SRC=$C08000 LEN=3 DST=$010 (upper nibble of $46 ignored)
    snes_write(13'h1F40, 8'h00);
    snes_write(13'h1F41, 8'h80);
    snes_write(13'h1F42, 8'hC0);
    snes_write(13'h1F43, 8'h03);
    snes_write(13'h1F44, 8'h00);
    snes_write(13'h1F45, 8'h10);
    snes_write(13'h1F46, 8'hF0);
    snes_read("rb_src2", 13'h1F42, RB ? 8'hC0 : 8'h00);
    snes_read("rb_dst1", 13'h1F46, 8'h00);
    snes_write(13'h1F47, 8'h00);
    do_byte("t1b0", 24'hC08000, 12'h010, 8'hA5, 1'b0);
    do_byte("t1b1", 24'hC08001, 12'h011, 8'h5A, 1'b0);
    do_byte("t1b2", 24'hC08002, 12'h012, 8'h3C, 1'b1);
    snes_read("rb_len0_after", 13'h1F43, RB ? 8'h03 : 8'h00);
    snes_read("rb_src0_after", 13'h1F41, RB ? 8'h80 : 8'h00);

    // Destination wrap at $BFF
    snes_write(13'h1F45, 8'hFE);
    snes_write(13'h1F46, 8'h0B);
    snes_read("rb_dst1_b", 13'h1F46, RB ? 8'h0B : 8'h00);
    snes_write(13'h1F47, 8'h11);
    do_byte("t2b0", 24'hC08000, 12'hBFE, 8'h01, 1'b0);
    do_byte("t2b1", 24'hC08001, 12'hBFF, 8'h02, 1'b0);
    do_byte("t2b2", 24'hC08002, 12'h000, 8'h03, 1'b1);

    // Source wrap at $FFFFFF
    snes_write(13'h1F40, 8'hFF);
    snes_write(13'h1F41, 8'hFF);
    snes_write(13'h1F42, 8'hFF);
    snes_write(13'h1F43, 8'h02);
    snes_write(13'h1F47, 8'h00);
    do_byte("t3b0", 24'hFFFFFF, 12'hBFE, 8'hE1, 1'b0);
    do_byte("t3b1", 24'h000000, 12'hBFF, 8'hE2, 1'b1);

    // LEN=0 start does nothing; stray ACK while idle is ignored
    snes_write(13'h1F43, 8'h00);
    snes_write(13'h1F47, 8'h00);
    quiet("len0_quiet", 10);
    snes_read("len0_status", 13'h1F5E, 8'h00);
    bus.DMA_ACK  = 1'b1;
    bus.DMA_DATA = 8'h99;
    quiet("idle_ack_quiet", 3);
    bus.DMA_ACK  = 1'b0;
    bus.DMA_DATA = 8'h00;

    // Writes while busy are ignored, including a second start
    snes_write(13'h1F40, 8'h56);
    snes_write(13'h1F41, 8'h34);
    snes_write(13'h1F42, 8'h12);
    snes_write(13'h1F43, 8'h02);
    snes_write(13'h1F45, 8'h10);
    snes_write(13'h1F46, 8'h00);
    snes_write(13'h1F47, 8'h00);
    wait_req("busy_wr");
    snes_write(13'h1F40, 8'h00);
    snes_write(13'h1F41, 8'h00);
    snes_write(13'h1F42, 8'h00);
    snes_write(13'h1F47, 8'h00);
    snes_read("busy_status", 13'h1F5E, 8'h40);
    snes_read("busy_rb_src0", 13'h1F40, RB ? 8'h56 : 8'h00);
    chk("busy_addr_kept", 32'(bus.DMA_ADDR), 32'h123456);
    do_byte("t4b0", 24'h123456, 12'h010, 8'h4B, 1'b0);
    do_byte("t4b1", 24'h123457, 12'h011, 8'hB4, 1'b1);
    quiet("no_restart", 10);

    // Reset while in REQ aborts immediately and clears registers
    snes_write(13'h1F47, 8'h00);
    wait_req("abort");
    #2;
    RST_N = 1'b0;
    #1;
    chk("abort_req", 32'(bus.DMA_REQ), 32'd0);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_we", 32'(bus.RAM_WE), 32'd0);
    bus.DMA_ACK  = 1'b1;
    bus.DMA_DATA = 8'h66;
    repeat (2) tick();
    bus.DMA_ACK  = 1'b0;
    bus.DMA_DATA = 8'h00;
    RST_N = 1'b1;
    quiet("abort_quiet", 10);
    snes_read("abort_src0", 13'h1F40, 8'h00);
    snes_read("abort_src2", 13'h1F42, 8'h00);
    snes_read("abort_len0", 13'h1F43, 8'h00);
    snes_read("abort_dst0", 13'h1F45, 8'h00);
    snes_read("abort_status", 13'h1F5E, 8'h00);

    // Fresh start after the abort
    snes_write(13'h1F40, 8'h00);
    snes_write(13'h1F41, 8'h01);
    snes_write(13'h1F43, 8'h01);
    snes_write(13'h1F45, 8'h20);
    snes_write(13'h1F47, 8'h00);
    do_byte("t5b0", 24'h000100, 12'h020, 8'h77, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
